// File: rtl/difftest_commit_monitor.sv
// Difftest commit monitor: counts RUN cycles and retired instructions, stops on trap,
// instruction limit or idle timeout. Define DIFFTEST_MONITOR_DISPLAY_EN to print the stop report and end simulation.
module difftest_commit_monitor #(
  parameter int              NUM_CH    = 6,
  parameter int unsigned     TIMEOUT   = 5000,
  parameter longint unsigned MAX_INSTR = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_CH-1:0]     io_commit_valid,
  input  logic [8*NUM_CH-1:0]   io_commit_nFused,
  input  logic                  io_hasTrap,
  input  logic [2:0]            io_code,
  input  logic [63:0]           io_pc,
  input  logic [7:0]            io_coreid,
  output logic [63:0]           io_cycleCnt,
  output logic [63:0]           io_instrCnt,
  output logic                  io_done,
  output logic [1:0]            io_result,
  output logic [63:0]           io_stopPC
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] RES_GOOD    = 2'd0;
  localparam logic [1:0] RES_BAD     = 2'd1;
  localparam logic [1:0] RES_TIMEOUT = 2'd2;
  localparam logic [1:0] RES_LIMIT   = 2'd3;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 32'd1);
  localparam logic [63:0] LIMIT        = 64'(MAX_INSTR);

  logic [1:0]  state_q, state_d;
  logic [63:0] cycle_cnt_q, cycle_cnt_d;
  logic [63:0] instr_cnt_q, instr_cnt_d;
  logic [31:0] idle_timer_q, idle_timer_d;
  logic        done_q, done_d;
  logic [1:0]  result_q, result_d;
  logic [63:0] stop_pc_q, stop_pc_d;

  logic [11:0] commit_sum;
  logic        any_commit;
  logic [64:0] instr_sum;
  logic [63:0] instr_next;
  logic [63:0] cycle_next;
  logic        limit_hit;
  logic        timeout_hit;

  // Each valid channel retires itself plus its fused partners; 8 * 256 fits in 12 bits.
  always_comb begin
    commit_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (io_commit_valid[i]) begin
        commit_sum = commit_sum + 12'd1 + 12'(io_commit_nFused[8*i +: 8]);
      end
    end
  end

  assign any_commit  = |io_commit_valid;
  assign instr_sum   = {1'b0, instr_cnt_q} + 65'(commit_sum);
  assign instr_next  = instr_sum[64] ? '1 : instr_sum[63:0];
  assign cycle_next  = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + 64'd1;
  assign limit_hit   = (LIMIT != 64'd0) && (instr_next >= LIMIT);
  assign timeout_hit = (TIMEOUT != 32'd0) && !any_commit && (idle_timer_q == TIMEOUT_LAST);

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    cycle_cnt_d  = cycle_cnt_q;
    instr_cnt_d  = instr_cnt_q;
    idle_timer_d = idle_timer_q;
    done_d       = done_q;
    result_d     = result_q;
    stop_pc_d    = stop_pc_q;
    if (enable) begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          cycle_cnt_d  = cycle_next;
          instr_cnt_d  = instr_next;
          idle_timer_d = any_commit ? 32'd0
                       : ((&idle_timer_q) ? idle_timer_q : idle_timer_q + 32'd1);
          // Trap beats instruction limit beats timeout.
          if (io_hasTrap) begin
            state_d   = DONE;
            done_d    = 1'b1;
            result_d  = (io_code == 3'd0) ? RES_GOOD : RES_BAD;
            stop_pc_d = io_pc;
          end else if (limit_hit) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = RES_LIMIT;
          end else if (timeout_hit) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = RES_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
      idle_timer_q <= '0;
      done_q       <= 1'b0;
      result_q     <= RES_GOOD;
      stop_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
      idle_timer_q <= idle_timer_d;
      done_q       <= done_d;
      result_q     <= result_d;
      stop_pc_q    <= stop_pc_d;
    end
  end

  assign io_cycleCnt = cycle_cnt_q;
  assign io_instrCnt = instr_cnt_q;
  assign io_done     = done_q;
  assign io_result   = result_q;
  assign io_stopPC   = stop_pc_q;

`ifdef DIFFTEST_MONITOR_DISPLAY_EN
  always @(posedge clock) begin
    if (!reset && state_q != DONE && state_d == DONE) begin
      case (result_d)
        RES_GOOD: $display("Core %0d: Hit Good Trap at pc 0x%h, cycles %0d, instrs %0d",
                           io_coreid, stop_pc_d, cycle_cnt_d, instr_cnt_d);
        RES_BAD:  $display("Core %0d: Hit Bad Trap at pc 0x%h, cycles %0d, instrs %0d",
                           io_coreid, stop_pc_d, cycle_cnt_d, instr_cnt_d);
        RES_TIMEOUT: $display("Core %0d: Timeout at pc 0x%h, cycles %0d, instrs %0d",
                              io_coreid, stop_pc_d, cycle_cnt_d, instr_cnt_d);
        default:  $display("Core %0d: Instr Limit at pc 0x%h, cycles %0d, instrs %0d",
                           io_coreid, stop_pc_d, cycle_cnt_d, instr_cnt_d);
      endcase
      $finish;
    end
  end
`else
  // Core id only appears in the optional stop report.
  logic unused_coreid;
  assign unused_coreid = ^io_coreid;
`endif

endmodule

// File: tb/tb_difftest_commit_monitor.sv
// Directed scoreboard bench for difftest_commit_monitor: one instance for counting/trap/timeout
// (TIMEOUT=16) and one for the instruction limit (MAX_INSTR=10, watchdog off).
module tb_difftest_commit_monitor;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, enable, has_trap;
  logic [1:0]  valid;
  logic [15:0] nfused;
  logic [2:0]  code;
  logic [63:0] pc;
  logic [7:0]  coreid;

  logic [63:0] a_cyc, a_ins, a_pc, b_cyc, b_ins, b_pc;
  logic        a_done, b_done;
  logic [1:0]  a_res, b_res;

  difftest_commit_monitor #(.NUM_CH(2), .TIMEOUT(16), .MAX_INSTR(0)) dut_a (
    .clock(clock), .reset(reset), .enable(enable),
    .io_commit_valid(valid), .io_commit_nFused(nfused),
    .io_hasTrap(has_trap), .io_code(code), .io_pc(pc), .io_coreid(coreid),
    .io_cycleCnt(a_cyc), .io_instrCnt(a_ins), .io_done(a_done),
    .io_result(a_res), .io_stopPC(a_pc)
  );

  difftest_commit_monitor #(.NUM_CH(2), .TIMEOUT(0), .MAX_INSTR(10)) dut_b (
    .clock(clock), .reset(reset), .enable(enable),
    .io_commit_valid(valid), .io_commit_nFused(nfused),
    .io_hasTrap(has_trap), .io_code(code), .io_pc(pc), .io_coreid(coreid),
    .io_cycleCnt(b_cyc), .io_instrCnt(b_ins), .io_done(b_done),
    .io_result(b_res), .io_stopPC(b_pc)
  );

  typedef struct {
    string       tag;
    bit          sel_b;
    logic [63:0] cyc;
    logic [63:0] ins;
    logic        done;
    logic [1:0]  res;
    logic [63:0] spc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit rst, bit en, logic [1:0] v, logic [15:0] nf,
                       bit trap, logic [2:0] c, logic [63:0] p);
    reset    = rst;
    enable   = en;
    valid    = v;
    nfused   = nf;
    has_trap = trap;
    code     = c;
    pc       = p;
  endtask

  task automatic push(string tag, bit sel_b, logic [63:0] cyc, logic [63:0] ins,
                      logic done, logic [1:0] res, logic [63:0] spc);
    exp_t e;
    e.tag = tag; e.sel_b = sel_b; e.cyc = cyc; e.ins = ins;
    e.done = done; e.res = res; e.spc = spc;
    sb.push_back(e);
  endtask

  // Advance one clock, then compare every expectation queued for that edge.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel_b) begin
        check({e.tag, ".cyc"},  b_cyc, e.cyc);
        check({e.tag, ".ins"},  b_ins, e.ins);
        check({e.tag, ".done"}, 64'(b_done), 64'(e.done));
        check({e.tag, ".res"},  64'(b_res), 64'(e.res));
        check({e.tag, ".pc"},   b_pc, e.spc);
      end else begin
        check({e.tag, ".cyc"},  a_cyc, e.cyc);
        check({e.tag, ".ins"},  a_ins, e.ins);
        check({e.tag, ".done"}, 64'(a_done), 64'(e.done));
        check({e.tag, ".res"},  64'(a_res), 64'(e.res));
        check({e.tag, ".pc"},   a_pc, e.spc);
      end
    end
  endtask

  initial begin
    coreid = 8'h03;
    drive(1, 0, 2'b00, 16'h0, 0, 3'd0, 64'h0);
    tick();
    push("rst_a", 0, 0, 0, 0, 0, 0);
    push("rst_b", 1, 0, 0, 0, 0, 0);
    tick();

    // Entry cycle: IDLE -> RUN without counting.
    drive(0, 1, 2'b00, 16'h0, 0, 3'd0, 64'h0);
    push("entry_a", 0, 0, 0, 0, 0, 0);
    push("entry_b", 1, 0, 0, 0, 0, 0);
    tick();

    // Ten cycles of two plain commits; B stops on its instruction limit at 10.
    drive(0, 1, 2'b11, 16'h0, 0, 3'd0, 64'h0);
    for (int i = 1; i <= 10; i++) begin
      push($sformatf("run_a%0d", i), 0, 64'(i), 64'(2*i), 0, 0, 0);
      if (i < 5) push($sformatf("run_b%0d", i), 1, 64'(i), 64'(2*i), 0, 0, 0);
      else       push($sformatf("limit_b%0d", i), 1, 5, 10, 1, 2'd3, 0);
      tick();
    end

    // Eight idle cycles, then enable low for five with commits and a trap present.
    drive(0, 1, 2'b00, 16'h0, 0, 3'd0, 64'h0);
    for (int k = 1; k <= 8; k++) begin
      push($sformatf("idle_a%0d", k), 0, 64'(10 + k), 20, 0, 0, 0);
      tick();
    end
    drive(0, 0, 2'b11, 16'h0101, 1, 3'd0, 64'h1234);
    for (int k = 1; k <= 5; k++) begin
      push($sformatf("frozen_a%0d", k), 0, 18, 20, 0, 0, 0);
      tick();
    end

    // Timer resumes from 8, so the watchdog fires on the eighth further idle cycle.
    drive(0, 1, 2'b00, 16'h0, 0, 3'd0, 64'h0);
    for (int k = 1; k <= 8; k++) begin
      push($sformatf("resume_a%0d", k), 0, 64'(18 + k), 20, (k == 8),
           (k == 8) ? 2'd2 : 2'd0, 0);
      tick();
    end
    drive(0, 1, 2'b11, 16'h0, 1, 3'd1, 64'h5);
    for (int k = 1; k <= 2; k++) begin
      push($sformatf("sticky_a%0d", k), 0, 26, 20, 1, 2'd2, 0);
      tick();
    end

    // Reset in DONE wins over enable, trap and commits.
    drive(1, 1, 2'b11, 16'h0, 1, 3'd0, 64'h9);
    push("rst_done_a", 0, 0, 0, 0, 0, 0);
    push("rst_done_b", 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 2'b00, 16'h0, 0, 3'd0, 64'h0);
    push("idle_hold_a", 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 2'b11, {8'd2, 8'd1}, 0, 3'd0, 64'h0);
    push("reentry_a", 0, 0, 0, 0, 0, 0);
    tick();

    // Fused commit then good trap in the following cycle.
    push("fused_a", 0, 1, 5, 0, 0, 0);
    tick();
    drive(0, 1, 2'b00, 16'h0, 1, 3'd0, 64'h8000_1000);
    push("good_trap_a", 0, 2, 5, 1, 2'd0, 64'h8000_1000);
    tick();
    drive(0, 1, 2'b11, 16'h0, 0, 3'd0, 64'h0);
    push("good_sticky_a", 0, 2, 5, 1, 2'd0, 64'h8000_1000);
    tick();

    // Pure timeout: done exactly on the 16th commit-free RUN cycle; B's watchdog is off.
    drive(1, 0, 2'b00, 16'h0, 0, 3'd0, 64'h0);
    tick();
    drive(0, 1, 2'b00, 16'h0, 0, 3'd0, 64'h0);
    push("to_entry_a", 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 1; k <= 16; k++) begin
      push($sformatf("to_a%0d", k), 0, 64'(k), 0, (k == 16), (k == 16) ? 2'd2 : 2'd0, 0);
      if (k == 16) push("no_wd_b", 1, 16, 0, 0, 0, 0);
      tick();
    end

    // Bad trap in the cycle the count reaches the limit: trap wins, its commits count.
    drive(1, 0, 2'b00, 16'h0, 0, 3'd0, 64'h0);
    push("rst_b2", 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 2'b00, 16'h0, 0, 3'd0, 64'h0);
    tick();
    drive(0, 1, 2'b11, 16'h0, 0, 3'd0, 64'h0);
    for (int k = 1; k <= 4; k++) begin
      push($sformatf("pre_b%0d", k), 1, 64'(k), 64'(2*k), 0, 0, 0);
      tick();
    end
    drive(0, 1, 2'b11, 16'h0, 1, 3'd3, 64'h8000_2000);
    push("trap_wins_b", 1, 5, 10, 1, 2'd1, 64'h8000_2000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
